datapath_arbiter: RTL and testbench

Shares the 8-bit register/ALU datapath (bus A/B source muxes, bus C write decoder, ALU) between two micro-op requesters: requester 0 is the sort state machine, requester 1 is a host/debug port. Each requester posts one micro-op (source A, source B, destination C, ALU function) with a req/ack handshake. The arbiter picks a winner, drives the datapath select lines for exactly one execute cycle, captures the ALU flags and returns them with a one-cycle ack. It sits between the requesters and the select inputs of the muxes, decoder and ALU.

---
 rtl/datapath_arbiter.sv | 121 ++++++++++++
 tb/tb_datapath_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/datapath_arbiter.sv
// Two-requester micro-op arbiter for the shared register/ALU datapath: IDLE -> EXEC -> ACK.
// Define DPARB_STRICT_PRIO_EN to make requester 0 win every tie instead of round-robin.
module datapath_arbiter #(
    parameter int unsigned SELECTIONDECO = 4,
    parameter int unsigned SELECTIONALU  = 3,
    parameter int unsigned IDLE_SELAB    = 0,
    parameter int unsigned IDLE_SELC     = 15
) (
    input  logic                     clk,
    input  logic                     highRst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [SELECTIONDECO-1:0] sSelA0,
    input  logic [SELECTIONDECO-1:0] sSelB0,
    input  logic [SELECTIONDECO-1:0] sSelC0,
    input  logic [SELECTIONALU-1:0]  sSelAlu0,
    input  logic [SELECTIONDECO-1:0] sSelA1,
    input  logic [SELECTIONDECO-1:0] sSelB1,
    input  logic [SELECTIONDECO-1:0] sSelC1,
    input  logic [SELECTIONALU-1:0]  sSelAlu1,
    input  logic [4:0]               sFlags,
    output logic [SELECTIONDECO-1:0] sSelDecoA,
    output logic [SELECTIONDECO-1:0] sSelDecoB,
    output logic [SELECTIONDECO-1:0] sSelDecoC,
    output logic [SELECTIONALU-1:0]  sSelAlu,
    output logic                     ack0,
    output logic                     ack1,
    output logic [4:0]               sFlagsOut,
    output logic                     busy,
    output logic                     grantId,
    output logic [7:0]               opCount
);

    localparam logic [SELECTIONDECO-1:0] IdleAb = SELECTIONDECO'(IDLE_SELAB);
    localparam logic [SELECTIONDECO-1:0] IdleC  = SELECTIONDECO'(IDLE_SELC);

    typedef enum logic [1:0] {StIdle, StExec, StAck} state_e;

    state_e state_q, state_d;
    logic   last_grant_q;
    logic   winner;

    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
`ifdef DPARB_STRICT_PRIO_EN
            winner = 1'b0;
`else
            winner = ~last_grant_q;
`endif
        end else begin
            winner = req1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req0 || req1) state_d = StExec;
            StExec:  state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (highRst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Op is captured straight into the output registers at grant so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (highRst) begin
            sSelDecoA    <= IdleAb;
            sSelDecoB    <= IdleAb;
            sSelDecoC    <= IdleC;
            sSelAlu      <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            sFlagsOut    <= '0;
            busy         <= 1'b0;
            grantId      <= 1'b0;
            opCount      <= '0;
            last_grant_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        grantId   <= winner;
                        busy      <= 1'b1;
                        sSelDecoA <= winner ? sSelA1 : sSelA0;
                        sSelDecoB <= winner ? sSelB1 : sSelB0;
                        sSelDecoC <= winner ? sSelC1 : sSelC0;
                        sSelAlu   <= winner ? sSelAlu1 : sSelAlu0;
                    end
                end
                StExec: begin
                    sFlagsOut    <= sFlags;
                    ack0         <= ~grantId;
                    ack1         <= grantId;
                    last_grant_q <= grantId;
                    sSelDecoA    <= IdleAb;
                    sSelDecoB    <= IdleAb;
                    sSelDecoC    <= IdleC;
                    sSelAlu      <= '0;
                end
                StAck: begin
                    ack0    <= 1'b0;
                    ack1    <= 1'b0;
                    busy    <= 1'b0;
                    opCount <= opCount + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter: reset, single op, tie arbitration, mid-op reset,
// op stability and opCount wrap. Inputs change and outputs are sampled on the falling edge.
module tb_datapath_arbiter;

    logic       clk = 1'b0;
    logic       highRst;
    logic       req0, req1;
    logic [3:0] sSelA0, sSelB0, sSelC0, sSelA1, sSelB1, sSelC1;
    logic [2:0] sSelAlu0, sSelAlu1;
    logic [4:0] sFlags;
    logic [3:0] sSelDecoA, sSelDecoB, sSelDecoC;
    logic [2:0] sSelAlu;
    logic       ack0, ack1, busy, grantId;
    logic [4:0] sFlagsOut;
    logic [7:0] opCount;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    datapath_arbiter dut (
        .clk       (clk),
        .highRst   (highRst),
        .req0      (req0),
        .req1      (req1),
        .sSelA0    (sSelA0),
        .sSelB0    (sSelB0),
        .sSelC0    (sSelC0),
        .sSelAlu0  (sSelAlu0),
        .sSelA1    (sSelA1),
        .sSelB1    (sSelB1),
        .sSelC1    (sSelC1),
        .sSelAlu1  (sSelAlu1),
        .sFlags    (sFlags),
        .sSelDecoA (sSelDecoA),
        .sSelDecoB (sSelDecoB),
        .sSelDecoC (sSelDecoC),
        .sSelAlu   (sSelAlu),
        .ack0      (ack0),
        .ack1      (ack1),
        .sFlagsOut (sFlagsOut),
        .busy      (busy),
        .grantId   (grantId),
        .opCount   (opCount)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        highRst = 1'b1;
        tick();
        tick();
        highRst = 1'b0;
    endtask

    logic exp_grant [3];

    initial begin
        highRst = 1'b1;
        {req0, req1} = 2'b00;
        {sSelA0, sSelB0, sSelC0, sSelA1, sSelB1, sSelC1} = '0;
        {sSelAlu0, sSelAlu1} = '0;
        sFlags = '0;

        // Reset values
        tick();
        tick();
        chk("rst_selA", 8'(sSelDecoA), 8'd0);
        chk("rst_selB", 8'(sSelDecoB), 8'd0);
        chk("rst_selC", 8'(sSelDecoC), 8'd15);
        chk("rst_alu", 8'(sSelAlu), 8'd0);
        chk("rst_acks", 8'({ack0, ack1}), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_opcount", opCount, 8'd0);
        chk("rst_flags", 8'(sFlagsOut), 8'd0);
        highRst = 1'b0;

        // Single op from requester 0
        req0 = 1'b1; sSelA0 = 4'd1; sSelB0 = 4'd2; sSelC0 = 4'd3; sSelAlu0 = 3'd1;
        tick();
        chk("single_exec_selA", 8'(sSelDecoA), 8'd1);
        chk("single_exec_selB", 8'(sSelDecoB), 8'd2);
        chk("single_exec_selC", 8'(sSelDecoC), 8'd3);
        chk("single_exec_alu", 8'(sSelAlu), 8'd1);
        chk("single_exec_busy", 8'(busy), 8'd1);
        chk("single_exec_noack", 8'({ack0, ack1}), 8'd0);
        sFlags = 5'b00010;
        req0 = 1'b0;
        tick();
        chk("single_ack0", 8'(ack0), 8'd1);
        chk("single_ack1", 8'(ack1), 8'd0);
        chk("single_flags", 8'(sFlagsOut), 8'h02);
        chk("single_grant", 8'(grantId), 8'd0);
        tick();
        chk("single_opcount", opCount, 8'd1);
        chk("single_busy_low", 8'(busy), 8'd0);
        chk("single_ack_end", 8'(ack0), 8'd0);
        chk("single_idle_selA", 8'(sSelDecoA), 8'd0);
        chk("single_idle_selC", 8'(sSelDecoC), 8'd15);

        // Tie arbitration from a fresh reset (lastGrant = 1)
        do_reset();
`ifdef DPARB_STRICT_PRIO_EN
        exp_grant = '{1'b0, 1'b0, 1'b0};
`else
        exp_grant = '{1'b0, 1'b1, 1'b0};
`endif
        sSelA0 = 4'd4; sSelB0 = 4'd5; sSelC0 = 4'd6; sSelAlu0 = 3'd2;
        sSelA1 = 4'd7; sSelB1 = 4'd8; sSelC1 = 4'd9; sSelAlu1 = 3'd3;
        sFlags = 5'b10101;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("tie%0d_grant", k), 8'(grantId), 8'(exp_grant[k]));
            chk($sformatf("tie%0d_selC", k), 8'(sSelDecoC), exp_grant[k] ? 8'd9 : 8'd6);
            tick();
            chk($sformatf("tie%0d_acks", k), 8'({ack1, ack0}), exp_grant[k] ? 8'd2 : 8'd1);
            if (k == 2) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
        end
        chk("tie_opcount", opCount, 8'd3);
        chk("tie_flags", 8'(sFlagsOut), 8'h15);

        // Reset while requester 1 is in EXEC
        do_reset();
        req1 = 1'b1; sSelC1 = 4'd9;
        tick();
        chk("midrst_grant", 8'(grantId), 8'd1);
        chk("midrst_busy_exec", 8'(busy), 8'd1);
        highRst = 1'b1; req1 = 1'b0;
        tick();
        chk("midrst_noack", 8'({ack0, ack1}), 8'd0);
        chk("midrst_selC", 8'(sSelDecoC), 8'd15);
        chk("midrst_busy", 8'(busy), 8'd0);
        chk("midrst_opcount", opCount, 8'd0);
        highRst = 1'b0;
        tick();
        chk("midrst_noack_after", 8'({ack0, ack1}), 8'd0);

        // Op inputs changed after grant
        req0 = 1'b1; sSelC0 = 4'd3;
        tick();
        req0 = 1'b0; sSelC0 = 4'd5;
        chk("stable_exec_selC", 8'(sSelDecoC), 8'd3);
        tick();
        chk("stable_ack0", 8'(ack0), 8'd1);
        tick();
        chk("stable_opcount", opCount, 8'd1);

        // opCount wrap over 256 back-to-back ops
        do_reset();
        req0 = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            tick();
            chk($sformatf("wrap%0d_ack0", i), 8'(ack0), 8'd1);
            if (i == 256) req0 = 1'b0;
            tick();
            chk($sformatf("wrap%0d_opcount", i), opCount, 8'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
